// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the serial pattern detectors: mode encoding, limits and
// elaboration-time KMP helpers (failure length and transition) reused across detectors.
package seq_detector_param_pkg;

  localparam int unsigned MAX_PAT_LEN = 32;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

  // Bit i of the pattern in arrival order (i=0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                   input int unsigned len, input int unsigned i);
    return pattern[len-1-i];
  endfunction

  // Longest proper border of the length-k prefix.
  function automatic int unsigned fail_len(input logic [MAX_PAT_LEN-1:0] pattern,
                                           input int unsigned len, input int unsigned k);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned b = 1; b < k; b++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < b; i++) begin
        if (pat_bit(pattern, len, i) != pat_bit(pattern, len, k - b + i)) ok = 1'b0;
      end
      if (ok) best = b;
    end
    return best;
  endfunction

  // KMP transition from prefix length k on input bit b.
  function automatic int unsigned next_len(input logic [MAX_PAT_LEN-1:0] pattern,
                                           input int unsigned len, input int unsigned k,
                                           input logic b);
    int unsigned cur;
    int unsigned res;
    logic        done;
    cur  = k;
    res  = 0;
    done = 1'b0;
    for (int unsigned it = 0; it <= MAX_PAT_LEN + 1; it++) begin
      if (!done) begin
        if (cur < len && pat_bit(pattern, len, cur) == b) begin
          res  = cur + 1;
          done = 1'b1;
        end else if (cur == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          cur = fail_len(pattern, len, cur);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_param_next.sv
// Combinational KMP transition delta(s,b); both per-state tables are folded to
// constants at elaboration so no runtime search remains.
module seq_det_next
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
  parameter int unsigned          SW      = 3
) (
  input  logic [SW-1:0] s,
  input  logic          b,
  output logic [SW-1:0] nxt
);

  logic [SW-1:0] nxt0 [PAT_LEN+1];
  logic [SW-1:0] nxt1 [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tab
    localparam int unsigned N0 = next_len(32'(PATTERN), PAT_LEN, k, 1'b0);
    localparam int unsigned N1 = next_len(32'(PATTERN), PAT_LEN, k, 1'b1);
    assign nxt0[k] = SW'(N0);
    assign nxt1[k] = SW'(N1);
  end

  always_comb begin
    nxt = '0;
    for (int unsigned k = 0; k <= PAT_LEN; k++) begin
      if (s == SW'(k)) nxt = b ? nxt1[k] : nxt0[k];
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: KMP prefix-length state, Moore or Mealy det,
// optional overlap, enable qualifier and saturating match counter.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
  parameter bit                   OVERLAP = 1'b1,
  parameter bit                   MOORE   = 1'b0,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned   SW      = $clog2(PAT_LEN + 1);
  localparam mode_e         MODE    = MOORE ? MODE_MOORE : MODE_MEALY;
  localparam logic [SW-1:0] FULL    = SW'(PAT_LEN);
  localparam logic [SW-1:0] RESTART = OVERLAP ? SW'(fail_len(32'(PATTERN), PAT_LEN, PAT_LEN)) : '0;

  logic [SW-1:0] s;
  logic [SW-1:0] s_eff;
  logic [SW-1:0] nxt;
  logic          m;
  logic          det_q;

  // The Moore accept state behaves as its restart point when computing the next step.
  always_comb s_eff = (s == FULL) ? RESTART : s;

  seq_det_next #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .SW      (SW)
  ) u_next (
    .s   (s_eff),
    .b   (j),
    .nxt (nxt)
  );

  assign m = en & (nxt == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      det_q <= 1'b0;
    end else if (en) begin
      if (MODE == MODE_MOORE) begin
        s     <= nxt;
        det_q <= m;
      end else begin
        s     <= m ? RESTART : nxt;
        det_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (m && match_cnt != '1) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  assign det = (MODE == MODE_MOORE) ? det_q : m;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: several parameterisations share one stream and are
// compared against a bit-history reference model, plus directed tables and sequences.
module tb_seq_detector_param;

  localparam int N = 9;
  localparam int unsigned LEN [N] = '{5, 5, 5, 5, 4, 4, 5, 7, 1};
  localparam logic [31:0] PAT [N] = '{32'b10010, 32'b10010, 32'b10010, 32'b10010,
                                      32'b1111, 32'b1111, 32'b10010, 32'b1101101, 32'b1};
  localparam bit OVL [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit MOO [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam int unsigned CW [N] = '{8, 8, 8, 8, 8, 8, 2, 8, 8};

  logic         clk;
  logic         rst;
  logic         en;
  logic         j;
  logic [N-1:0] det_v;
  logic [7:0]   cnt_v [N];

  for (genvar i = 0; i < N; i++) begin : g_dut
    logic [CW[i]-1:0] c;
    seq_detector_param #(
      .PAT_LEN (LEN[i]),
      .PATTERN (PAT[i][LEN[i]-1:0]),
      .OVERLAP (OVL[i]),
      .MOORE   (MOO[i]),
      .CNT_W   (CW[i])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .j         (j),
      .det       (det_v[i]),
      .match_cnt (c)
    );
    assign cnt_v[i] = 8'(c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw sampled-bit history, bits since the search (re)started,
  // Moore det value and match count.
  logic [63:0] hist_m  [N];
  int          since_m [N];
  bit          det_mo  [N];
  int          cnt_m   [N];
  bit          pre_hit [N];
  logic        pre_det [N];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic b);
    logic [63:0] h2;
    logic [63:0] mask;
    @(negedge clk);
    rst = r;
    en  = e;
    j   = b;
    #1;
    for (int i = 0; i < N; i++) begin
      h2   = {hist_m[i][62:0], b};
      mask = (64'd1 << LEN[i]) - 64'd1;
      pre_hit[i] = e && ((h2 & mask) == (64'(PAT[i]) & mask)) && (since_m[i] + 1 >= int'(LEN[i]));
      pre_det[i] = det_v[i];
      if (!MOO[i]) chk($sformatf("mealy_det[%0d]", i), int'(det_v[i]), int'(pre_hit[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        since_m[i] = 0;
        det_mo[i]  = 1'b0;
        cnt_m[i]   = 0;
      end else if (e) begin
        hist_m[i] = {hist_m[i][62:0], b};
        if (since_m[i] < 64) since_m[i]++;
        det_mo[i] = pre_hit[i];
        if (pre_hit[i]) begin
          if (cnt_m[i] < (1 << CW[i]) - 1) cnt_m[i]++;
          if (!OVL[i]) since_m[i] = 0;
        end
      end
      if (MOO[i]) chk($sformatf("moore_det[%0d]", i), int'(det_v[i]), int'(det_mo[i]));
      chk($sformatf("match_cnt[%0d]", i), int'(cnt_v[i]), cnt_m[i]);
    end
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k]);
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic j;
    logic det_a;
    logic det_b;
    int   cnt_a;
  } vec_t;

  vec_t tbl [11];
  int   exp6 [5];

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    j   = 1'b0;
    for (int i = 0; i < N; i++) begin
      hist_m[i]  = '0;
      since_m[i] = 0;
      det_mo[i]  = 1'b0;
      cnt_m[i]   = 0;
    end

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};

    // Stream 1,0,0,1,0,0,1,0,1 after a two-cycle reset.
    for (int v = 0; v < 11; v++) begin
      step(tbl[v].rst, tbl[v].en, tbl[v].j);
      chk($sformatf("tbl%0d_mealy_det", v), int'(pre_det[0]), int'(tbl[v].det_a));
      chk($sformatf("tbl%0d_moore_det", v), int'(det_v[1]), int'(tbl[v].det_b));
      chk($sformatf("tbl%0d_cnt", v), int'(cnt_v[0]), tbl[v].cnt_a);
    end
    chk("nooverlap_mealy_cnt", int'(cnt_v[2]), 1);
    chk("nooverlap_moore_cnt", int'(cnt_v[3]), 1);

    // Seven ones against 1111.
    step(1'b1, 1'b0, 1'b0);
    feed(32'b1111111, 7);
    chk("ones_overlap_cnt", int'(cnt_v[4]), 4);
    chk("ones_nooverlap_cnt", int'(cnt_v[5]), 1);

    // Enable gap of 3 cycles between bits 3 and 4 while j toggles.
    step(1'b1, 1'b0, 1'b0);
    feed(32'b100, 3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("en_gap_mealy_det", int'(pre_det[0]), 1);
    chk("en_gap_cnt", int'(cnt_v[0]), 1);

    // Saturation of the 2-bit counter.
    exp6 = '{1, 2, 3, 3, 3};
    step(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      feed(32'b10010, 5);
      chk($sformatf("sat_cnt_%0d", g), int'(cnt_v[6]), exp6[g]);
    end

    // Reset coinciding with the final pattern bit.
    step(1'b1, 1'b0, 1'b0);
    feed(32'b1001, 4);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_final_moore_det", int'(det_v[1]), 0);
    chk("rst_final_mealy_det", int'(det_v[0]), 0);
    chk("rst_final_cnt", int'(cnt_v[0]), 0);

    // Randomised stream, all instances checked against the model.
    for (int c = 0; c < 800; c++) begin
      step(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 9) < 8),
           logic'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
